// File: rtl/hilo_spec_buffer.sv
// ---------------------------------------------------------------------------
// hilo_spec_buffer
//
// HI/LO register pair with an in-order speculative write buffer. Execute-stage
// HI/LO writes from up to LANES lanes per cycle are queued in a circular
// buffer. Commit retires the oldest entries into the architectural HI/LO.
// Flush discards everything still pending. Readers see the architectural
// value with all pending writes overlaid, oldest to youngest.
//
// Optional build macro: HILO_BYPASS_EN
//   When defined, hi_rdata/lo_rdata also overlay the writes accepted this
//   cycle, so a write is visible with 0-cycle latency. When it is undefined,
//   there is no combinational path from wr_* to the read data.
//
// Ports
//   clk         in   clock; all state is updated on posedge
//   resetn      in   asynchronous reset, active low
//   wr_valid    in   [LANES]        lane i enqueues one entry
//   wr_hi_en    in   [LANES]        entry of lane i writes HI
//   wr_lo_en    in   [LANES]        entry of lane i writes LO
//   wr_hi_data  in   [LANES*WIDTH]  HI data, lane i at [i*WIDTH +: WIDTH]
//   wr_lo_data  in   [LANES*WIDTH]  LO data, same packing
//   wr_ready    out  room for a full group of LANES entries (registered count)
//   commit_cnt  in   number of oldest entries to retire this cycle
//   flush       in   drop all pending entries and this cycle's incoming writes
//   hi_rdata    out  speculative HI
//   lo_rdata    out  speculative LO
//   hi_arch     out  committed HI
//   lo_arch     out  committed LO
//   pend_cnt    out  number of pending entries
//   err         out  sticky protocol error (over-commit or enqueue when full)
// ---------------------------------------------------------------------------
module hilo_spec_buffer #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [LANES-1:0]             wr_valid,
  input  logic [LANES-1:0]             wr_hi_en,
  input  logic [LANES-1:0]             wr_lo_en,
  input  logic [LANES*WIDTH-1:0]       wr_hi_data,
  input  logic [LANES*WIDTH-1:0]       wr_lo_data,
  output logic                         wr_ready,
  input  logic [$clog2(LANES+1)-1:0]   commit_cnt,
  input  logic                         flush,
  output logic [WIDTH-1:0]             hi_rdata,
  output logic [WIDTH-1:0]             lo_rdata,
  output logic [WIDTH-1:0]             hi_arch,
  output logic [WIDTH-1:0]             lo_arch,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic                         err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage. Only slots inside [rd_ptr, rd_ptr+cnt) are meaningful, so
  // the storage itself needs no reset.
  logic [WIDTH-1:0] r_hi_mem [DEPTH];
  logic [WIDTH-1:0] r_lo_mem [DEPTH];
  logic [DEPTH-1:0] r_hi_en_mem;
  logic [DEPTH-1:0] r_lo_en_mem;

  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi_arch;
  logic [WIDTH-1:0] r_lo_arch;
  logic             r_err;

  logic [WIDTH-1:0] w_lane_hi   [LANES];
  logic [WIDTH-1:0] w_lane_lo   [LANES];
  logic [PW-1:0]    w_lane_slot [LANES];
  logic [CW-1:0]    w_in_cnt;

  logic             w_ready;
  logic             w_any_valid;
  logic             w_accept;
  logic             w_commit_over;
  logic [CW-1:0]    w_commit_req;
  logic [CW-1:0]    w_commit_n;
  logic [WIDTH-1:0] w_hi_arch_next;
  logic [WIDTH-1:0] w_lo_arch_next;
  logic [PW-1:0]    w_rd_ptr_next;
  logic [PW-1:0]    w_wr_ptr_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_err_set;
  logic [WIDTH-1:0] w_hi_spec;
  logic [WIDTH-1:0] w_lo_spec;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_hi[gi] = wr_hi_data[gi*WIDTH +: WIDTH];
      assign w_lane_lo[gi] = wr_lo_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Valid lanes are packed into consecutive slots in ascending lane order:
  // each lane's slot is wr_ptr plus the number of valid lanes below it.
  always_comb begin
    logic [CW-1:0] v_run;
    v_run = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_slot[i] = r_wr_ptr + v_run[PW-1:0];
      v_run          = v_run + CW'(wr_valid[i]);
    end
    w_in_cnt = v_run;
  end

  // Readiness looks only at the registered count, never at this cycle's commit.
  assign w_ready     = (CW'(DEPTH) - r_cnt) >= CW'(LANES);
  assign w_any_valid = |wr_valid;
  assign w_accept    = w_any_valid & w_ready & ~flush;

  // Over-commit is clamped to what is pending and flagged.
  always_comb begin
    w_commit_req  = CW'(commit_cnt);
    w_commit_over = (w_commit_req > r_cnt);
    w_commit_n    = w_commit_over ? r_cnt : w_commit_req;
  end

  // Retire oldest entries in order; later (younger) enables overwrite earlier.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_hi_arch_next = r_hi_arch;
    w_lo_arch_next = r_lo_arch;
    for (int k = 0; k < LANES; k++) begin
      v_idx = r_rd_ptr + PW'(k);
      if (CW'(k) < w_commit_n) begin
        if (r_hi_en_mem[v_idx]) w_hi_arch_next = r_hi_mem[v_idx];
        if (r_lo_en_mem[v_idx]) w_lo_arch_next = r_lo_mem[v_idx];
      end
    end
  end

  // Order within a cycle: commit, then flush, then enqueue. A flush
  // realigns the write pointer to the post-commit read pointer. An enqueue
  // attempt swallowed by a flush is not counted as a protocol error.
  always_comb begin
    w_rd_ptr_next = r_rd_ptr + w_commit_n[PW-1:0];
    w_err_set     = w_commit_over | (w_any_valid & ~w_ready & ~flush);
    if (flush) begin
      w_wr_ptr_next = w_rd_ptr_next;
      w_cnt_next    = '0;
    end else if (w_accept) begin
      w_wr_ptr_next = r_wr_ptr + w_in_cnt[PW-1:0];
      w_cnt_next    = r_cnt - w_commit_n + w_in_cnt;
    end else begin
      w_wr_ptr_next = r_wr_ptr;
      w_cnt_next    = r_cnt - w_commit_n;
    end
  end

  // Speculative view: architectural value overlaid by pending entries,
  // oldest first, HI and LO resolved independently.
  always_comb begin
    logic [PW-1:0] v_idx;
    w_hi_spec = r_hi_arch;
    w_lo_spec = r_lo_arch;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rd_ptr + PW'(k);
      if (CW'(k) < r_cnt) begin
        if (r_hi_en_mem[v_idx]) w_hi_spec = r_hi_mem[v_idx];
        if (r_lo_en_mem[v_idx]) w_lo_spec = r_lo_mem[v_idx];
      end
    end
`ifdef HILO_BYPASS_EN
    // Same-cycle accepted writes sit on top, youngest lane applied last.
    if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_valid[i] && wr_hi_en[i]) w_hi_spec = w_lane_hi[i];
        if (wr_valid[i] && wr_lo_en[i]) w_lo_spec = w_lane_lo[i];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_cnt     <= '0;
      r_hi_arch <= '0;
      r_lo_arch <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rd_ptr  <= w_rd_ptr_next;
      r_wr_ptr  <= w_wr_ptr_next;
      r_cnt     <= w_cnt_next;
      r_hi_arch <= w_hi_arch_next;
      r_lo_arch <= w_lo_arch_next;
      r_err     <= r_err | w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_valid[i]) begin
          r_hi_mem[w_lane_slot[i]]    <= w_lane_hi[i];
          r_lo_mem[w_lane_slot[i]]    <= w_lane_lo[i];
          r_hi_en_mem[w_lane_slot[i]] <= wr_hi_en[i];
          r_lo_en_mem[w_lane_slot[i]] <= wr_lo_en[i];
        end
      end
    end
  end

  assign wr_ready = w_ready;
  assign hi_rdata = w_hi_spec;
  assign lo_rdata = w_lo_spec;
  assign hi_arch  = r_hi_arch;
  assign lo_arch  = r_lo_arch;
  assign pend_cnt = r_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_hilo_spec_buffer.sv
// ---------------------------------------------------------------------------
// tb_hilo_spec_buffer
//
// Directed scenarios for hilo_spec_buffer (WIDTH=32, LANES=2, DEPTH=4).
// Expected architectural values are pushed to a queue when a commit is
// driven and popped for comparison after the clock edge that performs it.
// ---------------------------------------------------------------------------
module tb_hilo_spec_buffer;

  logic        clk;
  logic        resetn;
  logic [1:0]  wr_valid;
  logic [1:0]  wr_hi_en;
  logic [1:0]  wr_lo_en;
  logic [63:0] wr_hi_data;
  logic [63:0] wr_lo_data;
  logic        wr_ready;
  logic [1:0]  commit_cnt;
  logic        flush;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic [31:0] hi_arch;
  logic [31:0] lo_arch;
  logic [2:0]  pend_cnt;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  logic [31:0] eh;
  logic [31:0] el;

  hilo_spec_buffer #(.WIDTH(32), .LANES(2), .DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_valid   (wr_valid),
    .wr_hi_en   (wr_hi_en),
    .wr_lo_en   (wr_lo_en),
    .wr_hi_data (wr_hi_data),
    .wr_lo_data (wr_lo_data),
    .wr_ready   (wr_ready),
    .commit_cnt (commit_cnt),
    .flush      (flush),
    .hi_rdata   (hi_rdata),
    .lo_rdata   (lo_rdata),
    .hi_arch    (hi_arch),
    .lo_arch    (lo_arch),
    .pend_cnt   (pend_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wr_valid   = '0;
    wr_hi_en   = '0;
    wr_lo_en   = '0;
    wr_hi_data = '0;
    wr_lo_data = '0;
    commit_cnt = '0;
    flush      = 1'b0;
  endtask

  task automatic drive_lane(input int lane, input bit hen, input bit len,
                            input logic [31:0] h, input logic [31:0] l);
    wr_valid[lane]            = 1'b1;
    wr_hi_en[lane]            = hen;
    wr_lo_en[lane]            = len;
    wr_hi_data[lane*32 +: 32] = h;
    wr_lo_data[lane*32 +: 32] = l;
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
    exp_hi_q.push_back(h);
    exp_lo_q.push_back(l);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_idle();
    tick();
    tick();
    total++;
    if (hi_arch !== 32'h0 || lo_arch !== 32'h0) begin
      bad++;
      $display("FAIL reset_arch: got hi=%h lo=%h want 0/0", hi_arch, lo_arch);
    end
    total++;
    if (pend_cnt !== 3'd0 || err !== 1'b0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctl: got pend=%0d err=%b rdy=%b want 0/0/1", pend_cnt, err, wr_ready);
    end
    total++;
    if (hi_rdata !== 32'h0 || lo_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got hi=%h lo=%h want 0/0", hi_rdata, lo_rdata);
    end
    resetn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_single();
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h1111, 32'h0);
    tick();
    total++;
    if (hi_rdata !== 32'h1111 || hi_arch !== 32'h0 || pend_cnt !== 3'd1) begin
      bad++;
      $display("FAIL single_spec: got rdata=%h arch=%h pend=%0d want 1111/0/1", hi_rdata, hi_arch, pend_cnt);
    end
    drive_idle();
    commit_cnt = 2'd1;
    push_exp(32'h1111, 32'h0);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("single commit: hi_arch=%h lo_arch=%h", hi_arch, lo_arch);
    total++;
    if (hi_arch !== eh || lo_arch !== el || pend_cnt !== 3'd0) begin
      bad++;
      $display("FAIL single_commit: got hi=%h lo=%h pend=%0d want %h/%h/0", hi_arch, lo_arch, pend_cnt, eh, el);
    end
    drive_idle();
  endtask

  task automatic test_lane_order();
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'hA, 32'h0);
    drive_lane(1, 1'b1, 1'b1, 32'hB, 32'hC);
    tick();
    total++;
    if (hi_rdata !== 32'hB || lo_rdata !== 32'hC || pend_cnt !== 3'd2) begin
      bad++;
      $display("FAIL lane_spec: got hi=%h lo=%h pend=%0d want b/c/2", hi_rdata, lo_rdata, pend_cnt);
    end
    drive_idle();
    commit_cnt = 2'd2;
    push_exp(32'hB, 32'hC);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("lane-order commit: hi_arch=%h lo_arch=%h", hi_arch, lo_arch);
    total++;
    if (hi_arch !== eh || lo_arch !== el || pend_cnt !== 3'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL lane_commit: got hi=%h lo=%h pend=%0d err=%b want %h/%h/0/0", hi_arch, lo_arch, pend_cnt, err, eh, el);
    end
    drive_idle();
  endtask

  task automatic test_flush();
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h21, 32'h0);
    drive_lane(1, 1'b0, 1'b1, 32'h0, 32'h22);
    tick();
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h23, 32'h0);
    tick();
    total++;
    if (pend_cnt !== 3'd3 || hi_rdata !== 32'h23 || lo_rdata !== 32'h22 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_pre: got pend=%0d hi=%h lo=%h rdy=%b want 3/23/22/0", pend_cnt, hi_rdata, lo_rdata, wr_ready);
    end
    drive_idle();
    flush      = 1'b1;
    commit_cnt = 2'd1;
    drive_lane(0, 1'b1, 1'b1, 32'h99, 32'h98);
    push_exp(32'h21, 32'hC);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("flush commit: hi_arch=%h lo_arch=%h", hi_arch, lo_arch);
    total++;
    if (hi_arch !== eh || lo_arch !== el || pend_cnt !== 3'd0) begin
      bad++;
      $display("FAIL flush_commit: got hi=%h lo=%h pend=%0d want %h/%h/0", hi_arch, lo_arch, pend_cnt, eh, el);
    end
    total++;
    if (hi_rdata !== eh || lo_rdata !== el || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_rdata: got hi=%h lo=%h rdy=%b want %h/%h/1", hi_rdata, lo_rdata, wr_ready, eh, el);
    end
    drive_idle();
  endtask

  task automatic test_full();
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h41, 32'h0);
    drive_lane(1, 1'b1, 1'b0, 32'h42, 32'h0);
    tick();
    total++;
    if (pend_cnt !== 3'd2 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_half: got pend=%0d rdy=%b want 2/1", pend_cnt, wr_ready);
    end
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h43, 32'h0);
    drive_lane(1, 1'b0, 1'b0, 32'hEE, 32'hEE);  // no-op entry still takes a slot
    tick();
    total++;
    if (pend_cnt !== 3'd4 || wr_ready !== 1'b0 || hi_rdata !== 32'h43) begin
      bad++;
      $display("FAIL full_fill: got pend=%0d rdy=%b hi=%h want 4/0/43", pend_cnt, wr_ready, hi_rdata);
    end
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h45, 32'h0);
    tick();
    total++;
    if (err !== 1'b1 || pend_cnt !== 3'd4 || hi_rdata !== 32'h43) begin
      bad++;
      $display("FAIL full_overflow: got err=%b pend=%0d hi=%h want 1/4/43", err, pend_cnt, hi_rdata);
    end
    drive_idle();
    commit_cnt = 2'd2;
    push_exp(32'h42, 32'hC);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("full commit a: hi_arch=%h lo_arch=%h", hi_arch, lo_arch);
    total++;
    if (hi_arch !== eh || lo_arch !== el || pend_cnt !== 3'd2 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_commit_a: got hi=%h lo=%h pend=%0d rdy=%b want %h/%h/2/1", hi_arch, lo_arch, pend_cnt, wr_ready, eh, el);
    end
    commit_cnt = 2'd2;
    push_exp(32'h43, 32'hC);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("full commit b: hi_arch=%h lo_arch=%h", hi_arch, lo_arch);
    total++;
    if (hi_arch !== eh || lo_arch !== el || pend_cnt !== 3'd0) begin
      bad++;
      $display("FAIL full_commit_b: got hi=%h lo=%h pend=%0d want %h/%h/0", hi_arch, lo_arch, pend_cnt, eh, el);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    drive_idle();
    drive_lane(0, 1'b1, 1'b1, 32'd1, 32'd1 + 32'h100);
    tick();
    total++;
    if (hi_rdata !== 32'd1 || pend_cnt !== 3'd1) begin
      bad++;
      $display("FAIL wrap_first: got hi=%h pend=%0d want 1/1", hi_rdata, pend_cnt);
    end
    for (int j = 1; j <= 10; j++) begin
      drive_idle();
      if (j < 10) drive_lane(0, 1'b1, 1'b1, 32'(j + 1), 32'(j + 1 + 'h100));
      commit_cnt = 2'd1;
      push_exp(32'(j), 32'(j + 'h100));
      tick();
      eh = exp_hi_q.pop_front();
      el = exp_lo_q.pop_front();
      $display("wrap step %0d: hi_arch=%h lo_arch=%h pend=%0d", j, hi_arch, lo_arch, pend_cnt);
      total++;
      if (hi_arch !== eh || lo_arch !== el || pend_cnt !== ((j < 10) ? 3'd1 : 3'd0)) begin
        bad++;
        $display("FAIL wrap_%0d: got hi=%h lo=%h pend=%0d want %h/%h", j, hi_arch, lo_arch, pend_cnt, eh, el);
      end
    end
    drive_idle();
  endtask

  task automatic test_clamp();
    resetn = 1'b0;
    drive_idle();
    tick();
    total++;
    if (err !== 1'b0 || hi_arch !== 32'h0) begin
      bad++;
      $display("FAIL clamp_reset: got err=%b hi=%h want 0/0", err, hi_arch);
    end
    resetn = 1'b1;
    drive_lane(0, 1'b1, 1'b0, 32'h61, 32'h0);
    tick();
    drive_idle();
    commit_cnt = 2'd2;
    push_exp(32'h61, 32'h0);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("clamp commit: hi_arch=%h err=%b", hi_arch, err);
    total++;
    if (hi_arch !== eh || lo_arch !== el || pend_cnt !== 3'd0 || err !== 1'b1) begin
      bad++;
      $display("FAIL clamp_commit: got hi=%h lo=%h pend=%0d err=%b want %h/%h/0/1", hi_arch, lo_arch, pend_cnt, err, eh, el);
    end
    drive_idle();
    drive_lane(0, 1'b1, 1'b0, 32'h55, 32'h0);
    #1;
`ifdef HILO_BYPASS_EN
    eh = 32'h55;
`else
    eh = 32'h61;
`endif
    total++;
    if (hi_rdata !== eh) begin
      bad++;
      $display("FAIL bypass_same_cycle: got hi=%h want %h", hi_rdata, eh);
    end
    tick();
    total++;
    if (hi_rdata !== 32'h55 || hi_arch !== 32'h61 || pend_cnt !== 3'd1) begin
      bad++;
      $display("FAIL bypass_next: got rdata=%h arch=%h pend=%0d want 55/61/1", hi_rdata, hi_arch, pend_cnt);
    end
    drive_idle();
    commit_cnt = 2'd1;
    push_exp(32'h55, 32'h0);
    tick();
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    $display("post-clamp commit: hi_arch=%h err=%b", hi_arch, err);
    total++;
    if (hi_arch !== eh || lo_arch !== el || err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got hi=%h lo=%h err=%b want %h/%h/1", hi_arch, lo_arch, err, eh, el);
    end
    drive_idle();
  endtask

  task automatic test_reset_midop();
    drive_idle();
    drive_lane(0, 1'b1, 1'b1, 32'h71, 32'h72);
    tick();
    drive_idle();
    #2;
    resetn = 1'b0;
    #1;
    $display("async reset mid-cycle");
    total++;
    if (pend_cnt !== 3'd0 || err !== 1'b0 || wr_ready !== 1'b1 ||
        hi_rdata !== 32'h0 || lo_rdata !== 32'h0 || hi_arch !== 32'h0) begin
      bad++;
      $display("FAIL reset_midop: got pend=%0d err=%b rdy=%b hi=%h lo=%h arch=%h want 0/0/1/0/0/0",
               pend_cnt, err, wr_ready, hi_rdata, lo_rdata, hi_arch);
    end
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_lane_order();
    test_flush();
    test_full();
    test_back_to_back();
    test_clamp();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
